// File: rtl/fc_argmax_pkg.sv
// Shared types and helpers for the FC argmax stage.
// Holds the FSM state encoding and the index-width helper.
// Imported by fc_argmax_tracker and fc_argmax_stage.
package fc_argmax_pkg;

  // Two-state frame FSM: gather elements, then present the result.
  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_t;

  // Index/counter width; never narrower than one bit.
  function automatic int index_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/fc_argmax_tracker.sv
// Running max/index tracker for one frame of signed elements.
// Latency: max/index outputs already reflect the current beat (combinational view); registers update on the edge.
// Backpressure: none; it follows load_first/update_en strobes from the parent.
module fc_argmax_tracker
  import fc_argmax_pkg::*;
#(
  parameter int T    = 16,
  parameter int LOGM = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_first,
  input  logic                 update_en,
  input  logic signed [T-1:0]  data,
  input  logic [LOGM-1:0]      idx,
  output logic signed [T-1:0]  max,
  output logic [LOGM-1:0]      index
);

  logic signed [T-1:0] max_q;
  logic [LOGM-1:0]     index_q;

  // Candidate running state including the current beat; strict > keeps the lower index on ties.
  always_comb begin
    max   = max_q;
    index = index_q;
    if (load_first) begin
      max   = data;
      index = '0;
    end else if (update_en && (data > max_q)) begin
      max   = data;
      index = idx;
    end
  end

  // Commit the candidate whenever a beat is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      max_q   <= '0;
      index_q <= '0;
    end else if (load_first || update_en) begin
      max_q   <= max;
      index_q <= index;
    end
  end

endmodule

// File: rtl/fc_argmax_stage.sv
// Argmax over an M-element signed frame; emits {index, max} as one result beat.
// Latency: output_valid rises the cycle after the M-th element is accepted.
// Backpressure: output_ready low holds the result; input stalls (FC_ARGMAX_OVERLAP_EN lets the next frame stream in).
module fc_argmax_stage
  import fc_argmax_pkg::*;
#(
  parameter  int M    = 8,
  parameter  int T    = 16,
  localparam int LOGM = index_width(M)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 input_valid,
  output logic                 input_ready,
  input  logic signed [T-1:0]  input_data,
  output logic                 output_valid,
  input  logic                 output_ready,
  output logic [LOGM-1:0]      output_index,
  output logic signed [T-1:0]  output_max
);

  localparam logic [LOGM-1:0] LAST = LOGM'(M - 1);

  state_t              state;
  logic [LOGM-1:0]     count;
  logic                last_beat;
  logic                beat_acc;
  logic                out_hs;
  logic signed [T-1:0] cand_max;
  logic [LOGM-1:0]     cand_index;

  assign last_beat    = (count == LAST);
  assign output_valid = (state == EMIT);
  assign beat_acc     = input_valid && input_ready;
  assign out_hs       = output_valid && output_ready;

`ifdef FC_ARGMAX_OVERLAP_EN
  // Next frame may stream in while the result waits; only its final beat must wait for the result slot to free.
  assign input_ready = (state == COLLECT) || !last_beat || output_ready;
`else
  assign input_ready = (state == COLLECT);
`endif

  fc_argmax_tracker #(
    .T    (T),
    .LOGM (LOGM)
  ) u_tracker (
    .clk        (clk),
    .reset      (reset),
    .load_first (beat_acc && (count == '0)),
    .update_en  (beat_acc && (count != '0)),
    .data       (input_data),
    .idx        (count),
    .max        (cand_max),
    .index      (cand_index)
  );

  // Beat counter: advances per accepted element, wraps after the last one.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (beat_acc) begin
      count <= last_beat ? '0 : count + LOGM'(1);
    end
  end

  // Frame FSM: a final beat always (re)enters EMIT, even if the old result leaves in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= COLLECT;
    end else if (beat_acc && last_beat) begin
      state <= EMIT;
    end else if (out_hs) begin
      state <= COLLECT;
    end
  end

  // Result registers capture the final comparison and hold until the next frame completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      output_index <= '0;
      output_max   <= '0;
    end else if (beat_acc && last_beat) begin
      output_index <= cand_index;
      output_max   <= cand_max;
    end
  end

endmodule

// File: doc/fc_argmax_stage.md
Name: fc_argmax_stage

Overview:
- Downstream consumer of the fully-connected layer's output stream.
- Accepts one M-element output vector as M consecutive signed T-bit beats on a valid/ready handshake.
- Finds the maximum element and its index, then presents them as a single result beat on a valid/ready output handshake.
- Provides the classification decision at the end of the FC pipeline.

Parameters:
- M, 8: number of elements per frame; must equal the upstream layer's row count; M >= 2.
- T, 16: element width in bits; signed two's complement.
- LOGM (localparam), $clog2(M): width of the index and beat counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- input_valid  input  1  upstream holds a valid element on input_data.
- input_ready  output  1  block accepts the element this cycle.
- input_data  input  T  signed element, in index order 0..M-1.
- output_valid  output  1  result beat is present.
- output_ready  input  1  downstream accepts the result this cycle.
- output_index  output  LOGM  index of the maximum element.
- output_max  output  T  signed value of the maximum element.

Behaviour:
- Reset: reset, synchronous, active-high; clock clk.
  - State goes to COLLECT; beat counter = 0; running max/index = 0.
  - output_valid = 0, output_index = 0, output_max = 0.
  - Reset mid-frame or mid-EMIT discards all partial or pending data.
- Accept: an input beat is accepted iff input_valid && input_ready in the same cycle. An output beat is consumed iff output_valid && output_ready.
- COLLECT state:
  - input_ready = 1, output_valid = 0.
  - Beat with count == 0: unconditionally loads running max = input_data and running index = 0.
  - Beat with count k > 0: updates max/index only if input_data > running max (signed compare). Ties keep the lower index.
  - Counter increments on each accepted beat.
  - The accepted beat with count == M-1 updates the result registers (output_index, output_max) with the final comparison. Counter wraps to 0 and state moves to EMIT.
- EMIT state:
  - output_valid = 1; output_index and output_max are stable until consumed.
  - input_ready = 0 (base build).
  - On output handshake, return to COLLECT.
- Latency: output_valid rises on the cycle after the M-th beat is accepted. The earliest next-frame input acceptance is the cycle after the output handshake.
- Backpressure: output_ready low holds EMIT indefinitely. No input is lost because input_ready is low.
- input_valid gaps in COLLECT stall the counter; no state change occurs.
- Arithmetic: comparison only, full T-bit signed; no saturation needed. The most negative value (-2^(T-1)) is a legal element.
- output_data values outside EMIT are don't-care but must hold their last result (registered, no combinational path from input_data).

Optional Feature:
- Macro: FC_ARGMAX_OVERLAP_EN.
- Defined:
  - Running registers are separate from result registers.
  - In EMIT, input_ready = 1 while count < M-1, so the next frame's beats are accepted during backpressure.
  - input_ready = 0 when count == M-1 and the result is still unconsumed.
  - If the output handshake and the final beat coincide, the new result loads, output_valid stays 1, and state remains EMIT.
  - If the output handshake occurs with count < M-1, state returns to COLLECT and the partial frame is preserved.
- Undefined: base behaviour; input_ready = 0 throughout EMIT.

Decomposition:
- Package fc_argmax_pkg:
  - state enum (COLLECT, EMIT);
  - function to compute LOGM with minimum 1.
- One natural sub-module: fc_argmax_tracker.
  - Holds running max/index registers and the signed compare/update logic.
  - Inputs: load_first, update_en, data, idx.
  - Outputs: max, index.
- The top level holds the FSM, counter and result registers.

Test Plan:
- M=8, frame {3,10,7,10,0,2,9,1}, output_ready=1 -> output_index=1, output_max=10 (tie keeps lower index); output_valid rises the cycle after beat 8.
- Frame all -32768 -> index 0, max -32768. Frame {-5,-3,-9,-3,-20,-1,-7,-8} -> index 5, max -1.
- Random input_valid gaps (30% idle) on {0,0,0,0,0,0,0,42} -> index 7, max 42; exactly one output beat.
- output_ready held low 20 cycles after a result -> output_valid, index and max stable; input_ready=0 throughout (base). Then two back-to-back frames -> two correct results in order.
- reset asserted after 5 beats, then a full frame {1,2,3,4,5,6,7,8} -> single result index 7, max 8; no residue from the aborted frame.
- FC_ARGMAX_OVERLAP_EN:
  - Hold output_ready low while the next frame is streamed -> 7 beats accepted, input_ready drops on the 8th.
  - Release output_ready -> first result consumed, then second result correct.
